pipe_buffer: RTL and testbench

- Parametrised elastic pipeline stage buffer. Successor to the fixed single-register, en-bit stage structs (fetch_data_t, decode_data_t, and so on).
- Replaces the bare stall/enable stage register with valid/ready handshaking, DEPTH entries of buffering, and synchronous flush.
- Sits between any two pipeline stages. Callers pack their stage struct into in_data and size DATA_W with $bits(struct).

---
 rtl/pipes.sv | 18 +
 rtl/pipe_buffer_ptr.sv | 40 ++++
 rtl/pipe_buffer.sv | 118 +++++++++++
 tb/tb_pipe_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipes.sv
// Shared pipeline-stage types: handshake pair, default buffer depth and
// pointer sizing helper used by pipe_buffer and its pointer counters.
package pipes;

  parameter int unsigned PIPE_DEPTH_DEFAULT = 2;

  // Valid/ready pair for wiring stage-to-stage handshakes.
  typedef struct packed {
    logic valid;
    logic ready;
  } pipe_hs_t;

  // Pointer width for a buffer of the given depth; a single entry still needs one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buffer_ptr.sv
// Wrap-around pointer for the pipe_buffer ring: counts 0..DEPTH-1 and
// returns to 0, with a synchronous clear used for flush.
module pipe_buffer_ptr
  import pipes::*;
#(
  parameter int unsigned DEPTH = PIPE_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     inc,
  output logic [ptr_w(DEPTH)-1:0]  ptr
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer: clear wins, otherwise advance and wrap at DEPTH-1.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_buffer.sv
// Elastic valid/ready pipeline buffer with DEPTH entries and synchronous flush.
// Define PIPE_BUFFER_BYPASS_EN for a same-cycle pass-through when empty.
module pipe_buffer
  import pipes::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = PIPE_DEPTH_DEFAULT,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  pipe_hs_t          up_hs;
  pipe_hs_t          dn_hs;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              wr;
  logic              rd;
  logic              byp_c;

`ifdef PIPE_BUFFER_BYPASS_EN
  assign byp_c = (count_q == '0) & ~flush & in_valid;
`else
  assign byp_c = 1'b0;
`endif

  // Handshakes, output mux and occupancy update; in_ready only sees registered state.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(DEPTH));
    in_ready  = ~full;
    out_valid = ~empty | byp_c;
    out_data  = '0;
    if (!empty) begin
      out_data = mem_q[head];
    end else if (byp_c) begin
      out_data = in_data;
    end

    up_hs.valid = in_valid;
    up_hs.ready = in_ready;
    dn_hs.valid = out_valid;
    dn_hs.ready = out_ready;
    push = up_hs.valid & up_hs.ready;
    pop  = dn_hs.valid & dn_hs.ready;

    // A bypassed entry taken downstream this cycle never touches storage.
    wr = push & ~flush & ~(byp_c & out_ready);
    rd = pop & ~flush & ~byp_c;

    count_d = count_q + CNT_W'(wr) - CNT_W'(rd);
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; out_data is masked by occupancy instead.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[tail] <= in_data;
    end
  end

  pipe_buffer_ptr #(.DEPTH(DEPTH)) u_head (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (rd),
    .ptr   (head)
  );

  pipe_buffer_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (wr),
    .ptr   (tail)
  );

  assign count = count_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!(wr && full));
      assert (!(rd && empty));
      assert (count_q <= CNT_W'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_buffer.sv
// Randomized and directed bench for pipe_buffer: two instances (DEPTH 2 and 3)
// share one stimulus stream and are compared against queue-based models.
module tb_pipe_buffer;
  import pipes::*;

  localparam int unsigned DW = 64;
  localparam int unsigned DA = 2;
  localparam int unsigned DB = 3;

  typedef logic [DW-1:0] dq_t[$];

  logic clk;
  logic reset;
  logic flush;
  logic in_valid;
  logic out_ready;
  logic [DW-1:0] in_data;

  logic a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [$clog2(DA+1)-1:0] a_count;
  logic b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [$clog2(DB+1)-1:0] b_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  dq_t qa;
  dq_t qb;

  pipe_buffer #(.DATA_W(DW), .DEPTH(DA)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  pipe_buffer #(.DATA_W(DW), .DEPTH(DB)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit bypass_now(input dq_t q);
    bit b = 1'b0;
`ifdef PIPE_BUFFER_BYPASS_EN
    b = (q.size() == 0) && !flush && in_valid;
`endif
    return b;
  endfunction

  // Expected state after the edge, from the FIFO rules applied to the current inputs.
  function automatic dq_t next_q(input dq_t q, input int depth);
    bit byp;
    bit do_pop;
    bit do_push;
    if (!reset || flush) begin
      q.delete();
      return q;
    end
    byp     = bypass_now(q);
    do_pop  = out_ready && (q.size() != 0 || byp);
    do_push = in_valid && (q.size() != depth);
    if (byp && out_ready) return q;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(in_data);
    return q;
  endfunction

  task automatic check_side(input string p, input int depth, input dq_t q,
                            input logic ir, input logic ov, input logic [DW-1:0] od,
                            input logic [DW-1:0] cnt);
    bit byp;
    logic [DW-1:0] exp_d;
    byp   = bypass_now(q);
    exp_d = (q.size() != 0) ? q[0] : (byp ? in_data : '0);
    check({p, ".count"},     cnt, DW'(q.size()));
    check({p, ".in_ready"},  DW'(ir), DW'(q.size() != depth));
    check({p, ".out_valid"}, DW'(ov), DW'(q.size() != 0 || byp));
    check({p, ".out_data"},  od, exp_d);
  endtask

  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                     input logic fl, input logic rst);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
    if (chk_en) begin
      check_side("a", DA, qa, a_in_ready, a_out_valid, a_out_data, DW'(a_count));
      check_side("b", DB, qb, b_in_ready, b_out_valid, b_out_data, DW'(b_count));
    end
    @(posedge clk);
    qa = next_q(qa, DA);
    qb = next_q(qb, DB);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (qa.size() != 0 || qb.size() != 0); i++)
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    #1;
    check("a.drained", DW'(a_count), '0);
    check("b.drained", DW'(b_count), '0);
  endtask

  initial begin
    logic pv;
    logic [DW-1:0] pd;
    bit acc;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset then idle
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_en = 1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Fill DEPTH=2 with 0x11,0x22; 0x33 held upstream, then drain in order
    cyc(1'b1, 64'h11, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'h22, 1'b0, 1'b0, 1'b1);
    #1;
    check("a.full_count", DW'(a_count), 64'd2);
    check("a.full_ready", DW'(a_in_ready), 64'd0);
    check("a.head_11",    a_out_data, 64'h11);
    cyc(1'b1, 64'h33, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'h33, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 64'h33, 1'b1, 1'b0, 1'b1);
    drain();

    // Streaming 1..10
    for (int i = 1; i <= 10; i++) cyc(1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
    drain();

    // Flush with count=2 and a same-cycle push of 0xAA
    cyc(1'b1, 64'hA1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'hA2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'hAA, 1'b0, 1'b1, 1'b1);
    #1;
    check("a.flush_count", DW'(a_count), 64'd0);
    check("a.flush_valid", DW'(a_out_valid), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Reset mid-operation with count=2
    cyc(1'b1, 64'hB1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'hB2, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("a.rst_count", DW'(a_count), 64'd0);
    check("a.rst_valid", DW'(a_out_valid), 64'd0);
    check("a.rst_data",  a_out_data, 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

`ifdef PIPE_BUFFER_BYPASS_EN
    cyc(1'b1, 64'h55, 1'b1, 1'b0, 1'b1);
    #1;
    check("a.byp_count", DW'(a_count), 64'd0);
`endif

    // Randomized traffic; upstream holds in_valid/in_data until dut_a accepts
    pv = 1'b0;
    pd = '0;
    for (int i = 0; i < 800; i++) begin
      logic fl;
      logic rs;
      logic ordy;
      fl   = ($urandom_range(0, 15) == 0);
      rs   = ($urandom_range(0, 79) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      if (!pv) begin
        pv = ($urandom_range(0, 2) != 0);
        pd = {$urandom, $urandom};
      end
      acc = pv && (qa.size() != DA);
      cyc(pv, pd, ordy, fl, rs);
      if (acc || !rs) pv = 1'b0;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
